// File: rtl/cmd_sequencer_pkg.sv
// Shared command codes, default widths and sequencer state encoding.
package cmd_sequencer_pkg;
  localparam int CMD_W_DEF = 3;
  localparam int ARG_W_DEF = 32;

  localparam logic [2:0] CMD_NOP     = 3'd0;
  localparam logic [2:0] CMD_ADVANCE = 3'd1;
  localparam logic [2:0] CMD_STEP    = 3'd2;
  localparam logic [2:0] CMD_RUN     = 3'd3;
  localparam logic [2:0] CMD_STOP    = 3'd4;
  localparam logic [2:0] CMD_LOAD    = 3'd5;
  localparam logic [2:0] CMD_CLEAR   = 3'd6;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_DONE = 2'd2
  } seq_state_e;
endpackage

// File: rtl/cmd_sequencer_slot.sv
// One-deep per-source command buffer with saturating ADVANCE merge and drop detect.
module cmd_slot
  import cmd_sequencer_pkg::*;
#(
  parameter int CMD_W = CMD_W_DEF,
  parameter int ARG_W = ARG_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid_i,
  input  logic [CMD_W-1:0] req_cmd_i,
  input  logic [ARG_W-1:0] req_arg_i,
  input  logic             clr_i,
  output logic             pending_o,
  output logic [CMD_W-1:0] cmd_o,
  output logic [ARG_W-1:0] arg_o,
  output logic             drop_o
);
  logic             pending_q, pending_d;
  logic [CMD_W-1:0] cmd_q, cmd_d;
  logic [ARG_W-1:0] arg_q, arg_d;
  logic [ARG_W:0]   sum;
  logic             both_adv;

  always_comb begin
    pending_d = pending_q;
    cmd_d     = cmd_q;
    arg_d     = arg_q;
    drop_o    = 1'b0;
    sum       = {1'b0, arg_q} + {1'b0, req_arg_i};
    both_adv  = (cmd_q == CMD_W'(CMD_ADVANCE)) && (req_cmd_i == CMD_W'(CMD_ADVANCE));
    if (req_valid_i) begin
      // A slot being handed off this edge takes the new command fresh.
      if (!pending_q || clr_i) begin
        pending_d = 1'b1;
        cmd_d     = req_cmd_i;
        arg_d     = req_arg_i;
      end else if (both_adv) begin
        arg_d = sum[ARG_W] ? '1 : sum[ARG_W-1:0];
      end else begin
        drop_o = 1'b1;
      end
    end else if (clr_i) begin
      pending_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending_q <= 1'b0;
      cmd_q     <= '0;
      arg_q     <= '0;
    end else begin
      pending_q <= pending_d;
      cmd_q     <= cmd_d;
      arg_q     <= arg_d;
    end
  end

  assign pending_o = pending_q;
  assign cmd_o     = cmd_q;
  assign arg_o     = arg_q;
endmodule

// File: rtl/cmd_sequencer.sv
// Merges per-source command pulses into one round-robin, single-outstanding engine stream.
module cmd_sequencer
  import cmd_sequencer_pkg::*;
#(
  parameter int NREQ  = 3,
  parameter int CMD_W = CMD_W_DEF,
  parameter int ARG_W = ARG_W_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ*CMD_W-1:0] req_cmd,
  input  logic [NREQ*ARG_W-1:0] req_arg0,
  input  logic [NREQ-1:0]       req_valid,
  input  logic                  hold,
  input  logic                  drop_clr,
  output logic [CMD_W-1:0]      out_cmd,
  output logic [ARG_W-1:0]      out_arg0,
  output logic                  out_valid,
  input  logic                  out_ready,
  input  logic                  engine_done,
  output logic [2:0]            grant_id,
  output logic                  busy,
  output logic [NREQ-1:0]       drop_flags
);
  localparam int SW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]            pend, drop, clr;
  logic [NREQ-1:0][CMD_W-1:0] slot_cmd;
  logic [NREQ-1:0][ARG_W-1:0] slot_arg;

  seq_state_e       state_q;
  logic [SW-1:0]    last_q, grant_q;
  logic [CMD_W-1:0] out_cmd_q;
  logic [ARG_W-1:0] out_arg_q;
  logic             out_valid_q, busy_q;
  logic [NREQ-1:0]  drop_q;

  logic          hs, found;
  logic [SW-1:0] sel, idx;

  assign hs = (state_q == ST_ISSUE) && out_valid_q && out_ready;

  for (genvar g = 0; g < NREQ; g++) begin : g_slot
    assign clr[g] = hs && (grant_q == SW'(g));
    cmd_slot #(.CMD_W(CMD_W), .ARG_W(ARG_W)) u_slot (
      .clk        (clk),
      .reset      (reset),
      .req_valid_i(req_valid[g]),
      .req_cmd_i  (req_cmd[g*CMD_W +: CMD_W]),
      .req_arg_i  (req_arg0[g*ARG_W +: ARG_W]),
      .clr_i      (clr[g]),
      .pending_o  (pend[g]),
      .cmd_o      (slot_cmd[g]),
      .arg_o      (slot_arg[g]),
      .drop_o     (drop[g])
    );
  end

  // Rotate the scan start to last+1, then take the first pending source.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    idx   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = SW'((int'(last_q) + k) % NREQ);
      if (!found && pend[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      last_q      <= SW'(NREQ - 1);
      grant_q     <= '0;
      out_cmd_q   <= '0;
      out_arg_q   <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: if (!hold && found) begin
          out_cmd_q   <= slot_cmd[sel];
          out_arg_q   <= slot_arg[sel];
          out_valid_q <= 1'b1;
          grant_q     <= sel;
          last_q      <= sel;
          busy_q      <= 1'b1;
          state_q     <= ST_ISSUE;
        end
        ST_ISSUE: if (out_ready) begin
          out_valid_q <= 1'b0;
          state_q     <= ST_WAIT_DONE;
        end
        ST_WAIT_DONE: if (engine_done) begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

  // A new drop on the clearing edge still leaves its flag set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) drop_q <= '0;
    else       drop_q <= (drop_clr ? '0 : drop_q) | drop;
  end

  assign out_cmd    = out_cmd_q;
  assign out_arg0   = out_arg_q;
  assign out_valid  = out_valid_q;
  assign grant_id   = 3'(grant_q);
  assign busy       = busy_q;
  assign drop_flags = drop_q;
endmodule

// File: doc/cmd_sequencer.md
Name: cmd_sequencer

Overview:
- Merges command pulses from several independent sources into one serialized command stream for the life engine.
- Sources include the continuous-advance generator, single-step buttons and the host link.
- Each source fires one-cycle cmd_valid pulses with no backpressure. This block buffers one command per source, coalesces repeated ADVANCE requests, and arbitrates round-robin.
- It issues to the engine over a valid/ready handshake and keeps at most one command outstanding until the engine signals done.

Parameters:
- NREQ, 3, number of requesting sources (2..8).
- CMD_W, 3, command code width; must match command.vh.
- ARG_W, 32, argument width.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- req_cmd  in  NREQ*CMD_W  per-source command code; source i occupies slice [i*CMD_W +: CMD_W].
- req_arg0  in  NREQ*ARG_W  per-source argument; same slicing.
- req_valid  in  NREQ  one-cycle request pulses.
- hold  in  1  when high, no new issue starts; pending slots still fill and coalesce.
- drop_clr  in  1  clears drop_flags.
- out_cmd  out  CMD_W  command to engine.
- out_arg0  out  ARG_W  argument to engine.
- out_valid  out  1  command offered to engine.
- out_ready  in  1  engine accepts when out_valid & out_ready.
- engine_done  in  1  one-cycle pulse; engine finished the outstanding command.
- grant_id  out  3  index of the source last granted.
- busy  out  1  high in ISSUE and WAIT_DONE states.
- drop_flags  out  NREQ  sticky per-source overflow flags.

Behaviour:
- Reset:
  - All slots empty; state IDLE.
  - out_valid=0, out_cmd=0, out_arg0=0.
  - grant_id=0, busy=0, drop_flags=0.
  - Round-robin pointer last=NREQ-1, so source 0 has first priority.
- Per-source slot (pending bit, cmd, arg), on req_valid[i] at an edge:
  - Slot empty: load cmd/arg; pending=1.
  - Slot pending, stored cmd==CMD_ADVANCE and incoming cmd==CMD_ADVANCE: arg = stored + incoming, saturating at 2^ARG_W-1.
  - Slot pending, any other combination: incoming is dropped; drop_flags[i] set.
  - Slot being cleared by this edge's handshake: load the new command as if the slot were empty. Never coalesce into a command already handed off.
- drop_flags: drop_clr clears them. If drop_clr coincides with a new drop on the same edge, the set wins.
- State machine:
  - IDLE: if !hold and any slot pending:
    - Choose the first pending index scanning from last+1, wrapping modulo NREQ.
    - Register out_cmd/out_arg0 from that slot; out_valid=1; grant_id=index; last=index.
    - Go to ISSUE.
  - ISSUE: out_* held stable while out_valid=1.
    - On out_valid & out_ready: clear the granted slot; out_valid=0; go to WAIT_DONE.
    - hold has no effect once in ISSUE.
  - WAIT_DONE: on engine_done go to IDLE. engine_done in any other state is ignored.
- Latency:
  - req_valid in cycle t: slot pending in t+1.
  - out_valid rises in t+2 if IDLE with no competition.
  - Minimum spacing between consecutive issues is handshake cycle, then done cycle, then 1 IDLE cycle.
- Coalescing while in ISSUE never changes the registered out_arg0. Only the slot changes.
- Asynchronous reset mid-transaction returns everything to reset values immediately; a pending command is lost.

Decomposition:
- command.vh (shared):
  - CMD_* codes, including CMD_ADVANCE.
  - CMD_W and ARG_W defines used as parameter defaults.
- Sub-module cmd_slot: one per source, generated NREQ times.
  - Holds pending/cmd/arg.
  - Implements load, saturating ADVANCE coalescing, drop detection, and clear-with-reload priority.
- Round-robin selection stays in cmd_sequencer as a combinational rotate-and-priority-encode.

Test Plan:
- Single ADVANCE, arg=1, from source 0, out_ready=1: out_valid in t+2 with cmd=CMD_ADVANCE, arg=1, grant_id=0. engine_done 5 cycles later returns busy to 0.
- Source 1 pulses ADVANCE arg=1 three times while busy: one issue follows with arg=3 and drop_flags=0.
- Slot pending with ADVANCE, arg=0xFFFFFFFE, then ADVANCE arg=5 arrives: issued arg=0xFFFFFFFF (saturated).
- Non-ADVANCE command pending and second pulse on same source: second is dropped and drop_flags[i]=1. drop_clr then clears it; simultaneous drop and drop_clr leaves the flag set.
- All three sources pending at once, repeated for 6 issues: grant_id sequence 0,1,2,0,1,2.
- out_ready low 4 cycles: out_cmd/out_arg0 stable and out_valid=1 throughout. reset asserted during WAIT_DONE: all outputs return to 0 asynchronously, and the next request is granted to source 0.
